// File: rtl/da_pkg.sv
// Shared constants and loader state encoding for the DA partial-sum bank.
package da_pkg;

  localparam int unsigned DA_DATA_W    = 20;
  localparam int unsigned DA_ADDR_W    = 11;
  localparam int unsigned DA_NBLK      = 8;
  localparam int unsigned DA_BLK_DEPTH = 256;

  // Loader FSM encoding, kept as plain constants for older consumers.
  localparam logic [2:0] LD_IDLE  = 3'd0;
  localparam logic [2:0] LD_DRAIN = 3'd1;
  localparam logic [2:0] LD_LOAD  = 3'd2;
  localparam logic [2:0] LD_FLUSH = 3'd3;
  localparam logic [2:0] LD_DONE  = 3'd4;

  // A load must write at least one word and no more than the whole bank.
  function automatic logic da_count_ok(input logic [31:0] count, input int unsigned addr_w);
    return (count != 32'd0) && (count <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/da_ld_addr_gen.sv
// Bank address walker for a coefficient load: base load, wrapping increment,
// remaining-word down-counter and a flag for the final word.
module da_ld_addr_gen #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned CNT_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q;

  // Latch base/count on start; advance one word per accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (start) begin
      addr_q <= base;
      rem_q  <= count;
    end else if (step) begin
      // Natural overflow gives the 2047 -> 0 wrap.
      addr_q <= addr_q + 1'b1;
      rem_q  <= rem_q - 1'b1;
    end
  end

  assign addr = addr_q;
  assign last = (rem_q == CNT_W'(1));

endmodule

// File: rtl/da_coeff_loader.sv
// Load sequencer for the 8-block DA partial-sum SRAM bank. Streams coefficients
// into the bank and keeps the filter start away from it while a load is running.
module da_coeff_loader
  import da_pkg::*;
#(
  parameter int unsigned DATA_W = DA_DATA_W,
  parameter int unsigned ADDR_W = DA_ADDR_W,
  parameter int unsigned CNT_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              abort,
  input  logic              coef_valid,
  input  logic [DATA_W-1:0] coef_data,
  output logic              coef_ready,
  input  logic              da_start_in,
  input  logic              da_busy,
  output logic              da_start,
  output logic [DATA_W-1:0] CIN,
  output logic [ADDR_W-1:0] CADDR,
  output logic              CLOAD,
  output logic              WEN,
  output logic              CEN,
  output logic              busy,
  output logic              load_done,
  output logic              table_valid,
  output logic              cfg_err
);

  logic [2:0]        state_q, state_d;
  logic              count_ok, start_load, in_load, beat;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last;

  logic [DATA_W-1:0] cin_q;
  logic [ADDR_W-1:0] caddr_q;
  logic              cload_q, wen_q, cen_q, table_valid_q, cfg_err_q;

  assign count_ok   = da_count_ok(32'(cfg_count), ADDR_W);
  assign start_load = (state_q == LD_IDLE) && load_req && count_ok;
  assign in_load    = (state_q == LD_DRAIN) || (state_q == LD_LOAD) || (state_q == LD_FLUSH);
  // Abort withdraws ready so a coincident word is never taken from the stream.
  assign coef_ready = (state_q == LD_LOAD) && !abort;
  assign beat       = coef_valid && coef_ready;

  da_ld_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .start (start_load),
    .base  (cfg_base),
    .count (cfg_count),
    .step  (beat),
    .addr  (gen_addr),
    .last  (gen_last)
  );

  // Next-state logic for the load sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE:  if (start_load) state_d = LD_DRAIN;
      LD_DRAIN: begin
        if (abort)         state_d = LD_IDLE;
        else if (!da_busy) state_d = LD_LOAD;
      end
      LD_LOAD: begin
        if (abort)                 state_d = LD_IDLE;
        else if (beat && gen_last) state_d = LD_FLUSH;
      end
      LD_FLUSH: state_d = abort ? LD_IDLE : LD_DONE;
      LD_DONE:  state_d = LD_IDLE;
      default:  state_d = LD_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= LD_IDLE;
    else       state_q <= state_d;
  end

  // Registered bank pins and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cin_q         <= '0;
      caddr_q       <= '0;
      cload_q       <= 1'b0;
      wen_q         <= 1'b1;
      cen_q         <= 1'b1;
      table_valid_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      // Each accepted word owns exactly the following cycle on the bank.
      wen_q <= !beat;
      cen_q <= !beat;
      if (beat) begin
        cin_q   <= coef_data;
        caddr_q <= gen_addr;
      end
      cload_q   <= (state_d == LD_DRAIN) || (state_d == LD_LOAD) || (state_d == LD_FLUSH);
      cfg_err_q <= (state_q == LD_IDLE) && load_req && !count_ok;
      if (start_load)                          table_valid_q <= 1'b0;
      else if (state_q == LD_FLUSH && !abort) table_valid_q <= 1'b1;
    end
  end

  assign CIN         = cin_q;
  assign CADDR       = caddr_q;
  assign CLOAD       = cload_q;
  assign WEN         = wen_q;
  assign CEN         = cen_q;
  assign table_valid = table_valid_q;
  assign cfg_err     = cfg_err_q;
  assign busy        = (state_q != LD_IDLE);
  assign load_done   = (state_q == LD_DONE);
  assign da_start    = da_start_in && (state_q == LD_IDLE) && table_valid_q && !in_load;

endmodule

// File: tb/tb_da_coeff_loader.sv
// Randomised self-checking bench for da_coeff_loader.
module tb_da_coeff_loader;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 12;
  localparam int BANK   = 2048;

  logic              clk = 1'b0;
  logic              reset, load_req, abort, coef_valid, coef_ready;
  logic              da_start_in, da_busy, da_start, CLOAD, WEN, CEN;
  logic              busy, load_done, table_valid, cfg_err;
  logic [ADDR_W-1:0] cfg_base, CADDR;
  logic [CNT_W-1:0]  cfg_count;
  logic [DATA_W-1:0] coef_data, CIN;

  int checks = 0, failures = 0, cyc = 0;
  int obs_addr[$], obs_data[$], obs_cyc[$];
  int exp_addr[$], exp_data[$], exp_cyc[$];
  int done_cnt = 0, done_cyc = -1, err_cnt = 0, start_cnt = 0;
  int start_bad = 0, strobe_bad = 0, busy_cnt = 0;

  da_coeff_loader dut (
    .clk         (clk),
    .reset       (reset),
    .load_req    (load_req),
    .cfg_base    (cfg_base),
    .cfg_count   (cfg_count),
    .abort       (abort),
    .coef_valid  (coef_valid),
    .coef_data   (coef_data),
    .coef_ready  (coef_ready),
    .da_start_in (da_start_in),
    .da_busy     (da_busy),
    .da_start    (da_start),
    .CIN         (CIN),
    .CADDR       (CADDR),
    .CLOAD       (CLOAD),
    .WEN         (WEN),
    .CEN         (CEN),
    .busy        (busy),
    .load_done   (load_done),
    .table_valid (table_valid),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: log bank writes and event pulses mid-cycle.
  always @(negedge clk) begin
    if (!WEN) begin
      obs_addr.push_back(int'(CADDR));
      obs_data.push_back(int'(CIN));
      obs_cyc.push_back(cyc);
    end
    if (load_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (cfg_err) err_cnt = err_cnt + 1;
    if (da_start) start_cnt = start_cnt + 1;
    if (da_start && busy) start_bad = start_bad + 1;
    if ((WEN != CEN) || (!WEN && !CLOAD)) strobe_bad = strobe_bad + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  // Mismatches between logged writes (from index o0) and the expected write list;
  // a write must land exactly one cycle after its word was accepted.
  function automatic int write_errs(input int o0);
    int n = obs_addr.size() - o0;
    int e = (n == exp_addr.size()) ? 0 : 1;
    int m = (n < exp_addr.size()) ? n : exp_addr.size();
    for (int i = 0; i < m; i++)
      if (obs_addr[o0+i] != exp_addr[i] || obs_data[o0+i] != exp_data[i] ||
          obs_cyc[o0+i] != exp_cyc[i] + 1) e++;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stream driver: issues a load and feeds words, building the expected write list
  // (address = base + k mod 2048). Optionally stops with abort (kind 0) or reset (kind 1).
  task automatic drive_load(input int base, input int count, input int mode,
                            input int busy_cycles, input int stop_after, input int stop_kind,
                            input bit poke, output int req_cyc, output int first_cyc,
                            output int last_cyc);
    int beats = 0;
    int bc = 1;
    int lim = 2 * count + busy_cycles + 20;
    bit poked = 1'b0;
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    first_cyc = -1; last_cyc = -1;
    cfg_base = base[ADDR_W-1:0];
    cfg_count = count[CNT_W-1:0];
    load_req = 1'b1;
    da_busy = (busy_cycles > 0);
    req_cyc = cyc;
    tick(1);
    load_req = 1'b0;
    for (int i = 0; i < lim && beats < count; i++) begin
      da_busy = (bc < busy_cycles);
      bc++;
      case (mode)
        0:       coef_valid = 1'b1;
        1:       coef_valid = (i % 2 == 0);
        default: coef_valid = 1'($urandom_range(0, 1));
      endcase
      coef_data = DATA_W'($urandom);
      if (poke && beats == 1 && !poked) begin
        load_req = 1'b1;
        cfg_count = '0;
        poked = 1'b1;
      end
      if (beats == stop_after) begin
        coef_valid = 1'b1;
        if (stop_kind == 0) abort = 1'b1;
        else reset = 1'b1;
        tick(1);
        abort = 1'b0; reset = 1'b0; coef_valid = 1'b0; da_busy = 1'b0;
        return;
      end
      @(negedge clk);
      if (coef_valid && coef_ready) begin
        exp_addr.push_back((base + beats) % BANK);
        exp_data.push_back(int'(coef_data));
        exp_cyc.push_back(cyc);
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
      tick(1);
      load_req = 1'b0;
    end
    coef_valid = 1'b0;
    da_busy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; da_start_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({coef_ready, da_start, CLOAD, WEN, CEN} !== 5'b00011) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00011", {coef_ready, da_start, CLOAD, WEN, CEN});
    end
    checks++;
    if ({busy, load_done, table_valid, cfg_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_status got=%b want=0000", {busy, load_done, table_valid, cfg_err});
    end
    checks++;
    if (CIN !== '0 || CADDR !== '0) begin
      failures++;
      $display("FAIL reset_bus got CIN=%0h CADDR=%0h want 0/0", CIN, CADDR);
    end
    tick(1);
    reset = 1'b0; da_start_in = 1'b0;
    tick(2);
  endtask

  task automatic test_full_load();
    int o0 = obs_addr.size();
    int d0 = done_cnt;
    int r, f, l;
    drive_load(0, 2048, 0, 0, -1, 0, 1'b0, r, f, l);
    tick(5);
    checks++;
    if (obs_addr.size() - o0 != 2048) begin
      failures++;
      $display("FAIL full_count got=%0d want=2048", obs_addr.size() - o0);
    end
    checks++;
    if (write_errs(o0) != 0) begin
      failures++;
      $display("FAIL full_writes bad=%0d want=0", write_errs(o0));
    end
    checks++;
    if (f != r + 2) begin
      failures++;
      $display("FAIL full_first_beat got=%0d want=%0d", f, r + 2);
    end
    checks++;
    if (done_cnt - d0 != 1 || done_cyc != l + 2) begin
      failures++;
      $display("FAIL full_done pulses=%0d at=%0d want 1 at %0d", done_cnt - d0, done_cyc, l + 2);
    end
    checks++;
    if (table_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL full_status tv=%b busy=%b want 1/0", table_valid, busy);
    end
  endtask

  task automatic test_wrap();
    int o0 = obs_addr.size();
    int r, f, l;
    drive_load(2046, 4, 0, 0, -1, 0, 1'b0, r, f, l);
    tick(5);
    checks++;
    if (write_errs(o0) != 0) begin
      failures++;
      $display("FAIL wrap_writes bad=%0d n=%0d want 0 bad of 4", write_errs(o0),
               obs_addr.size() - o0);
    end
    if (obs_addr.size() - o0 == 4) begin
      checks++;
      if (obs_addr[o0+1] != 2047 || obs_addr[o0+2] != 0) begin
        failures++;
        $display("FAIL wrap_addr got=%0d,%0d want=2047,0", obs_addr[o0+1], obs_addr[o0+2]);
      end
    end
  endtask

  task automatic test_bubbles();
    int o0 = obs_addr.size();
    int e0 = err_cnt;
    int d0 = done_cnt;
    int r, f, l;
    drive_load(int'($urandom_range(0, 2047)), 8, 1, 0, -1, 0, 1'b1, r, f, l);
    tick(5);
    checks++;
    if (obs_addr.size() - o0 != 8 || write_errs(o0) != 0) begin
      failures++;
      $display("FAIL bubble_writes n=%0d bad=%0d want 8/0", obs_addr.size() - o0, write_errs(o0));
    end
    checks++;
    if (err_cnt != e0 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL bubble_flags cfg_err=%0d done=%0d want 0/1", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_drain();
    int o0 = obs_addr.size();
    int s0 = start_cnt;
    int r, f, l;
    da_start_in = 1'b1;
    drive_load(int'($urandom_range(0, 2047)), 5, 0, 10, -1, 0, 1'b0, r, f, l);
    da_start_in = 1'b0;
    tick(5);
    checks++;
    if (f != r + 11) begin
      failures++;
      $display("FAIL drain_first_beat got=%0d want=%0d", f, r + 11);
    end
    checks++;
    if (write_errs(o0) != 0) begin
      failures++;
      $display("FAIL drain_writes bad=%0d want=0", write_errs(o0));
    end
    // Only the request cycle itself (old table still valid) may forward a start.
    checks++;
    if (start_cnt - s0 != 1) begin
      failures++;
      $display("FAIL drain_da_start got=%0d want=1", start_cnt - s0);
    end
    da_start_in = 1'b1;
    @(negedge clk);
    checks++;
    if (da_start !== 1'b1) begin
      failures++;
      $display("FAIL idle_da_start got=%b want=1", da_start);
    end
    tick(1);
    da_start_in = 1'b0;
  endtask

  task automatic test_abort();
    int r, f, l;
    for (int k = 0; k < 2; k++) begin
      int o0 = obs_addr.size();
      int d0 = done_cnt;
      int n = (k == 0) ? 3 : 5;
      drive_load(int'($urandom_range(0, 2047)), 16, 0, 0, n, k, 1'b0, r, f, l);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || CLOAD !== 1'b0 || WEN !== 1'b1) begin
        failures++;
        $display("FAIL stop%0d_state busy=%b CLOAD=%b WEN=%b want 0/0/1", k, busy, CLOAD, WEN);
      end
      tick(4);
      checks++;
      if (obs_addr.size() - o0 != n || write_errs(o0) != 0) begin
        failures++;
        $display("FAIL stop%0d_writes n=%0d bad=%0d want %0d/0", k, obs_addr.size() - o0,
                 write_errs(o0), n);
      end
      checks++;
      if (table_valid !== 1'b0 || done_cnt != d0) begin
        failures++;
        $display("FAIL stop%0d_flags tv=%b done=%0d want 0/0", k, table_valid, done_cnt - d0);
      end
    end
  endtask

  task automatic test_cfg_err();
    int bad [3] = '{0, 3000, 2049};
    for (int k = 0; k < 3; k++) begin
      int o0 = obs_addr.size();
      int e0 = err_cnt;
      int b0 = busy_cnt;
      cfg_base = ADDR_W'($urandom);
      cfg_count = bad[k][CNT_W-1:0];
      load_req = 1'b1;
      tick(1);
      load_req = 1'b0;
      tick(3);
      checks++;
      if (err_cnt - e0 != 1) begin
        failures++;
        $display("FAIL cfg_err_%0d pulses=%0d want=1", bad[k], err_cnt - e0);
      end
      checks++;
      if (busy_cnt != b0 || obs_addr.size() != o0) begin
        failures++;
        $display("FAIL cfg_quiet_%0d busy=%0d writes=%0d want 0/0", bad[k], busy_cnt - b0,
                 obs_addr.size() - o0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int r, f, l;
    for (int k = 0; k < 6; k++) begin
      int o0 = obs_addr.size();
      int d0 = done_cnt;
      int cnt = int'($urandom_range(1, 40));
      drive_load(int'($urandom_range(0, 2047)), cnt, 2, int'($urandom_range(0, 3)), -1, 0,
                 1'b0, r, f, l);
      tick(2);
      checks++;
      if (obs_addr.size() - o0 != cnt || write_errs(o0) != 0) begin
        failures++;
        $display("FAIL b2b%0d_writes n=%0d bad=%0d want %0d/0", k, obs_addr.size() - o0,
                 write_errs(o0), cnt);
      end
      checks++;
      if (done_cnt - d0 != 1 || done_cyc != l + 2 || table_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b%0d_done pulses=%0d at=%0d tv=%b want 1 at %0d tv=1", k,
                 done_cnt - d0, done_cyc, table_valid, l + 2);
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (start_bad != 0 || strobe_bad != 0) begin
      failures++;
      $display("FAIL invariants start_while_busy=%0d strobe_bad=%0d want 0/0", start_bad,
               strobe_bad);
    end
  endtask

  initial begin
    reset = 1'b1; load_req = 1'b0; abort = 1'b0; coef_valid = 1'b0; coef_data = '0;
    da_start_in = 1'b0; da_busy = 1'b0; cfg_base = '0; cfg_count = '0;
    test_reset();
    test_full_load();
    test_wrap();
    test_bubbles();
    test_drain();
    test_abort();
    test_cfg_err();
    test_back_to_back();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
